// File: rtl/aha_reset_sequencer.sv
// Multi-channel active-low reset generator: power-on, gated system request and
// per-channel 4-phase software requests, with programmable hold and ordered release.
module aha_reset_sequencer #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 8,
    parameter int STAGGER = 2
) (
    input  logic              CLK,
    input  logic              PORESET,
    input  logic              SYS_REQ,
    input  logic [NUM_CH-1:0] SYS_EN,
    input  logic [NUM_CH-1:0] REQ,
    output logic [NUM_CH-1:0] ACK,
    input  logic [CNT_W-1:0]  HOLD_CYCLES,
    output logic [NUM_CH-1:0] RESETn,
    output logic              BUSY
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_DONE = 2'd2} state_e;
    localparam logic [7:0] STAGGER_L = 8'(STAGGER);

    state_e                       state_q [NUM_CH];
    state_e                       state_d [NUM_CH];
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]            src_q, src_d;
    logic [NUM_CH-1:0]            ack_q, ack_d;
    logic [NUM_CH-1:0]            rstn_q, rstn_d;
    logic [7:0]                   gap_q, gap_d;
    logic [NUM_CH-1:0]            trig, in_hold, blocked, not_idle;
    logic [CNT_W-1:0]             hold_load;

    assign trig      = REQ | (SYS_EN & {NUM_CH{SYS_REQ}});
    assign hold_load = (HOLD_CYCLES == '0) ? '0 : HOLD_CYCLES - CNT_W'(1);

    // A channel may only release once every lower-index channel has left HOLD.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_dec
        assign in_hold[i]  = (state_q[i] == S_HOLD);
        assign not_idle[i] = (state_q[i] != S_IDLE);
        if (i == 0) begin : g_first
            assign blocked[i] = 1'b0;
        end else begin : g_rest
            assign blocked[i] = |in_hold[i-1:0];
        end
    end

    always_comb begin
        gap_d  = (gap_q != 8'd0) ? gap_q - 8'd1 : gap_q;
        cnt_d  = cnt_q;
        src_d  = src_q;
        ack_d  = ack_q;
        rstn_d = rstn_q;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (trig[i]) begin
                        state_d[i] = S_HOLD;
                        rstn_d[i]  = 1'b0;
                        cnt_d[i]   = hold_load;
                        src_d[i]   = REQ[i];
                    end
                end
                S_HOLD: begin
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end else if (gap_q == 8'd0 && !blocked[i]) begin
                        state_d[i] = S_DONE;
                        rstn_d[i]  = 1'b1;
                        ack_d[i]   = src_q[i];
                        gap_d      = STAGGER_L;
                    end
                end
                S_DONE: begin
                    if (!trig[i]) begin
                        state_d[i] = S_IDLE;
                        ack_d[i]   = 1'b0;
                        src_d[i]   = 1'b0;
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // Power-on parks every channel in HOLD with an expired count so the
    // normal ordered release produces the power-on sequence.
    always_ff @(posedge CLK or posedge PORESET) begin
        if (PORESET) begin
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= S_HOLD;
            cnt_q  <= '0;
            src_q  <= '0;
            ack_q  <= '0;
            rstn_q <= '0;
            gap_q  <= 8'd0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
            cnt_q  <= cnt_d;
            src_q  <= src_d;
            ack_q  <= ack_d;
            rstn_q <= rstn_d;
            gap_q  <= gap_d;
        end
    end

    assign RESETn = rstn_q;
    assign ACK    = ack_q;
    assign BUSY   = |not_idle;
endmodule
